// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_W     : segments per digit (a..g)
//   DIGIT_W   : bits per hex digit
//   SEG_BLANK : active-low pattern for a dark digit
//   hex_to_seg: nibble -> active-low segment pattern, bit0=a .. bit6=g
package seven_seg_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [DIGIT_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_hex_lut.sv
// Combinational hex-nibble to seven-segment decoder (active-low).
//   nibble_i : 4-bit hex digit
//   seg_o    : segments, bit0=a .. bit6=g, 0 = lit
module seven_seg_hex_lut
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble_i,
  output logic [SEG_W-1:0]   seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multi-digit hex display driver with a frame-synchronous double buffer.
// A load strobe captures value/dp/blank into a shadow register; the shadow is
// committed to the active register only at the end of a scan frame, so the
// display never shows a half-updated value. Two output buses are registered
// from the active value: a time-multiplexed scan bus and a parallel bus.
//
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high
//   value_in       : packed digits, digit i = value_in[4i+3:4i]
//   dp_in          : decimal point request per digit, 1 = lit
//   blank_mask     : 1 = force digit dark
//   load           : 1-cycle capture strobe
//   update_pending : shadow holds uncommitted data
//   seg_out        : scan segments, active-low
//   dp_out         : scan decimal point, active-low
//   digit_en       : one-hot-low digit select
//   hex_all        : parallel segments, digit i = [7i+6:7i], active-low
//
// Build option: define LEADING_ZERO_BLANK_EN to darken digits above the most
// significant nonzero digit (digit 0 always shown).
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          load,
  output logic                          update_pending,
  output logic [SEG_W-1:0]              seg_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [SEG_W*NUM_DIGITS-1:0]   hex_all
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = DIGIT_W * NUM_DIGITS;
  localparam int HEX_W = SEG_W * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic                  pend_q, pend_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [HEX_W-1:0]      hex_q, hex_d;

  logic                  tick;
  logic                  commit;
  logic [HEX_W-1:0]      dec_bus;
  logic [NUM_DIGITS-1:0] dark;
  logic [NUM_DIGITS-1:0] lz_blank;

  assign tick   = (cnt_q == CNT_LAST);
  assign commit = tick && (idx_q == IDX_LAST);

  // Prescaler, scan index and double buffer.
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    sh_val_d    = sh_val_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    pend_d      = pend_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (load && commit) begin
      // A load landing on the frame boundary goes straight to the display.
      act_val_d   = value_in;
      act_dp_d    = dp_in;
      act_blank_d = blank_mask;
      pend_d      = 1'b0;
    end else if (load) begin
      sh_val_d   = value_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_mask;
      pend_d     = 1'b1;
    end else if (commit && pend_q) begin
      act_val_d   = sh_val_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
      pend_d      = 1'b0;
    end
  end

  // One decoder per digit; the scan bus selects from this bus.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
    seven_seg_hex_lut u_lut (
      .nibble_i (act_val_q[DIGIT_W*g +: DIGIT_W]),
      .seg_o    (dec_bus[SEG_W*g +: SEG_W])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk down from the top digit; a digit is suppressed while every digit
  // from it upward is zero.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (act_val_q[DIGIT_W*i +: DIGIT_W] == '0);
      lz_blank[i] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign dark = act_blank_q | lz_blank;

  always_comb begin
    hex_d = '0;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    en_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[SEG_W*i +: SEG_W] = dark[i] ? SEG_BLANK : dec_bus[SEG_W*i +: SEG_W];
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        seg_d    = hex_d[SEG_W*i +: SEG_W];
        dp_d     = dark[i] | ~act_dp_q[i];
        en_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pend_q      <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      en_q        <= '1;
      hex_q       <= '1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_val_q    <= sh_val_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      en_q        <= en_d;
      hex_q       <= hex_d;
    end
  end

  assign update_pending = pend_q;
  assign seg_out        = seg_q;
  assign dp_out         = dp_q;
  assign digit_en       = en_q;
  assign hex_all        = hex_q;

endmodule
